// File: rtl/pixsel_pipe.sv
// Per-pixel effect selector (grey / tint / passthrough) with frame-synchronous mode switching.
// Latency: 2 cycles accept-to-out_valid (3 when PIXSEL_BLEND_EN is defined); 1 beat/cycle.
// Backpressure: valid/ready skid-free pipeline; in_ready = any stage free or out_ready; out_* hold while stalled.
//
// Optional macro PIXSEL_BLEND_EN: adds a blend stage mixing tinted and original values by ALPHA/16.
module pixsel_pipe #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 3,
    parameter int VS_BIT = 0,
    parameter int UP_OFS = 64,
    parameter int DN_OFS = 32,
    parameter int ALPHA  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_skin,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_u,
    input  logic [DATA_W-1:0] in_v,
    input  logic [CTRL_W-1:0] in_c,
    input  logic [7:0]        in_swt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [3:0]        out_mode
);

    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0] LP_UP  = SW'(UP_OFS);
    localparam logic signed [SW-1:0] LP_DN  = SW'(DN_OFS);
    localparam logic signed [SW-1:0] LP_MAX = SW'((1 << DATA_W) - 1);

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_UP   = 2'd1,
        OP_DN   = 2'd2
    } op_e;

    // Saturating raise: clamps at full scale instead of wrapping.
    function automatic logic [DATA_W-1:0] f_up(input logic [DATA_W-1:0] x);
        logic signed [SW-1:0] s;
        s = $signed({2'b00, x}) + LP_UP;
        if (s > LP_MAX) s = LP_MAX;
        return s[DATA_W-1:0];
    endfunction

    // Saturating lower: clamps at zero instead of wrapping.
    function automatic logic [DATA_W-1:0] f_dn(input logic [DATA_W-1:0] x);
        logic signed [SW-1:0] s;
        s = $signed({2'b00, x}) - LP_DN;
        if (s[SW-1]) s = '0;
        return s[DATA_W-1:0];
    endfunction

    // Switch decode: all-ones is mode 9, otherwise lowest set bit k gives k+1.
    function automatic logic [3:0] f_decode(input logic [7:0] swt);
        logic [3:0] m;
        m = 4'd0;
        if (swt == 8'hFF) begin
            m = 4'd9;
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (swt[k]) m = 4'(k + 1);
            end
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] f_pick(input op_e op, input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] up,
                                                 input logic [DATA_W-1:0] dn);
        logic [DATA_W-1:0] o;
        case (op)
            OP_UP:   o = up;
            OP_DN:   o = dn;
            default: o = x;
        endcase
        return o;
    endfunction

    // ---------------- handshake ----------------
    logic w_ld1;
    logic w_ld2;
    logic w_acc;
    logic r_v1;
    logic r_v2;

`ifdef PIXSEL_BLEND_EN
    logic r_v3;
    logic w_ld3;
    assign w_ld3 = !r_v3 || out_ready;
    assign w_ld2 = !r_v2 || w_ld3;
`else
    assign w_ld2 = !r_v2 || out_ready;
`endif
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;
    assign w_acc    = in_valid && in_ready;

    // ---------------- frame-synchronous mode ----------------
    logic       r_prev_vs;
    logic [3:0] r_mode;
    logic       w_vs;
    logic       w_fs;
    logic [3:0] w_mode_eff;

    assign w_vs       = in_c[VS_BIT];
    assign w_fs       = w_vs && !r_prev_vs;
    // The frame-start beat itself already runs with the newly decoded mode.
    assign w_mode_eff = w_fs ? f_decode(in_swt) : r_mode;
    assign out_mode   = r_mode;

    // Latch the switches only at a 0->1 vsync edge seen on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_vs <= 1'b0;
            r_mode    <= 4'd0;
        end else if (w_acc) begin
            r_prev_vs <= w_vs;
            if (w_fs) r_mode <= w_mode_eff;
        end
    end

    // ---------------- stage 1: register inputs, pre-compute up/dn ----------------
    rgb_t              r_s1_x;
    rgb_t              r_s1_up;
    rgb_t              r_s1_dn;
    logic [DATA_W-1:0] r_s1_y;
    logic [DATA_W-1:0] r_s1_u;
    logic [DATA_W-1:0] r_s1_v;
    logic              r_s1_skin;
    logic [CTRL_W-1:0] r_s1_ctrl;
    logic [3:0]        r_s1_mode;

    // Stage 1 advances whenever stage 2 can take its content or it is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_s1_x    <= '0;
            r_s1_up   <= '0;
            r_s1_dn   <= '0;
            r_s1_y    <= '0;
            r_s1_u    <= '0;
            r_s1_v    <= '0;
            r_s1_skin <= 1'b0;
            r_s1_ctrl <= '0;
            r_s1_mode <= 4'd0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_x    <= '{r: in_r, g: in_g, b: in_b};
                r_s1_up   <= '{r: f_up(in_r), g: f_up(in_g), b: f_up(in_b)};
                r_s1_dn   <= '{r: f_dn(in_r), g: f_dn(in_g), b: f_dn(in_b)};
                r_s1_y    <= in_y;
                r_s1_u    <= in_u;
                r_s1_v    <= in_v;
                r_s1_skin <= in_skin;
                r_s1_ctrl <= in_c;
                r_s1_mode <= w_mode_eff;
            end
        end
    end

    // ---------------- stage 2: effect selection ----------------
    op_e  w_op_r;
    op_e  w_op_g;
    op_e  w_op_b;
    logic w_hit;
    rgb_t w_sel;

    // Resolve which pixels the mode targets and the per-channel operation.
    always_comb begin
        w_op_r = OP_PASS;
        w_op_g = OP_PASS;
        w_op_b = OP_PASS;
        w_hit  = 1'b0;
        case (r_s1_mode)
            4'd4: begin w_hit = r_s1_skin;  w_op_r = OP_DN; w_op_g = OP_UP; w_op_b = OP_DN; end
            4'd5: begin w_hit = r_s1_skin;  w_op_r = OP_UP; w_op_g = OP_DN; w_op_b = OP_DN; end
            4'd6: begin w_hit = r_s1_skin;  w_op_r = OP_DN; w_op_g = OP_DN; w_op_b = OP_UP; end
            4'd7: begin w_hit = r_s1_skin;  w_op_r = OP_UP; w_op_g = OP_UP; w_op_b = OP_UP; end
            4'd8: begin w_hit = !r_s1_skin; w_op_r = OP_UP; w_op_g = OP_UP; w_op_b = OP_UP; end
            4'd9: begin w_hit = !r_s1_skin; w_op_r = OP_DN; w_op_g = OP_DN; w_op_b = OP_DN; end
            default: begin end
        endcase
        if (!w_hit) begin
            w_op_r = OP_PASS;
            w_op_g = OP_PASS;
            w_op_b = OP_PASS;
        end
    end

    // Final per-channel value: grey modes override, otherwise tint or pass.
    always_comb begin
        w_sel.r = f_pick(w_op_r, r_s1_x.r, r_s1_up.r, r_s1_dn.r);
        w_sel.g = f_pick(w_op_g, r_s1_x.g, r_s1_up.g, r_s1_dn.g);
        w_sel.b = f_pick(w_op_b, r_s1_x.b, r_s1_up.b, r_s1_dn.b);
        case (r_s1_mode)
            4'd1:    w_sel = '{r: r_s1_y, g: r_s1_y, b: r_s1_y};
            4'd2:    w_sel = '{r: r_s1_u, g: r_s1_u, b: r_s1_u};
            4'd3:    w_sel = '{r: r_s1_v, g: r_s1_v, b: r_s1_v};
            default: begin end
        endcase
    end

    rgb_t              r_s2_px;
    logic [CTRL_W-1:0] r_s2_ctrl;

`ifdef PIXSEL_BLEND_EN
    localparam int BW = DATA_W + 5;
    localparam logic [BW-1:0] LP_A  = BW'(ALPHA);
    localparam logic [BW-1:0] LP_NA = BW'(16 - ALPHA);

    // Weighted mix in sixteenths; the sum never exceeds full scale * 16.
    function automatic logic [DATA_W-1:0] f_blend(input logic [DATA_W-1:0] t,
                                                  input logic [DATA_W-1:0] x);
        logic [BW-1:0] acc;
        acc = BW'(t) * LP_A + BW'(x) * LP_NA;
        return acc[DATA_W+3:4];
    endfunction

    rgb_t              r_s2_x;
    logic              r_s2_hit;
    rgb_t              r_s3_px;
    logic [CTRL_W-1:0] r_s3_ctrl;

    // Stage 2 holds the tinted value alongside the original for the blend stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_px   <= '0;
            r_s2_x    <= '0;
            r_s2_hit  <= 1'b0;
            r_s2_ctrl <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_px   <= w_sel;
                r_s2_x    <= r_s1_x;
                r_s2_hit  <= w_hit;
                r_s2_ctrl <= r_s1_ctrl;
            end
        end
    end

    // Stage 3 blends targeted pixels only; grey and passthrough go straight out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3      <= 1'b0;
            r_s3_px   <= '0;
            r_s3_ctrl <= '0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_s3_ctrl <= r_s2_ctrl;
                if (r_s2_hit) begin
                    r_s3_px <= '{r: f_blend(r_s2_px.r, r_s2_x.r),
                                 g: f_blend(r_s2_px.g, r_s2_x.g),
                                 b: f_blend(r_s2_px.b, r_s2_x.b)};
                end else begin
                    r_s3_px <= r_s2_px;
                end
            end
        end
    end

    assign out_valid = r_v3;
    assign out_r     = r_s3_px.r;
    assign out_g     = r_s3_px.g;
    assign out_b     = r_s3_px.b;
    assign out_ctrl  = r_s3_ctrl;
`else
    // Stage 2 is the output register; it only changes when empty or consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_px   <= '0;
            r_s2_ctrl <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_px   <= w_sel;
                r_s2_ctrl <= r_s1_ctrl;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_r     = r_s2_px.r;
    assign out_g     = r_s2_px.g;
    assign out_b     = r_s2_px.b;
    assign out_ctrl  = r_s2_ctrl;
`endif

endmodule

// File: tb/tb_pixsel_pipe.sv
// Self-checking bench for pixsel_pipe: directed effect cases plus a randomized stream
// scored against a reference model built from the arithmetic rules.
// Drives inputs 1 time unit after the rising edge and samples on the falling edge.
module tb_pixsel_pipe;

    localparam int DW    = 8;
    localparam int CW    = 3;
    localparam int VSB   = 0;
    localparam int UP    = 64;
    localparam int DN    = 32;
    localparam int ALPHA = 8;
    localparam int MAXV  = (1 << DW) - 1;
`ifdef PIXSEL_BLEND_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_skin;
    logic [DW-1:0] in_r, in_g, in_b, in_y, in_u, in_v;
    logic [CW-1:0] in_c;
    logic [7:0]    in_swt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r, out_g, out_b;
    logic [CW-1:0] out_ctrl;
    logic [3:0]    out_mode;

    pixsel_pipe #(
        .DATA_W(DW), .CTRL_W(CW), .VS_BIT(VSB),
        .UP_OFS(UP), .DN_OFS(DN), .ALPHA(ALPHA)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_skin(in_skin),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .in_c(in_c), .in_swt(in_swt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_ctrl(out_ctrl), .out_mode(out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int r;
        int g;
        int b;
        int c;
    } px_t;

    px_t q[$];
    int  m_mode    = 0;
    int  m_prev_vs = 0;

    function automatic int f_up(input int x);
        return (x + UP > MAXV) ? MAXV : x + UP;
    endfunction

    function automatic int f_dn(input int x);
        return (x - DN < 0) ? 0 : x - DN;
    endfunction

    // Lowest set bit index via isolating it arithmetically.
    function automatic int f_dec(input int swt);
        if (swt == 255) return 9;
        if (swt == 0) return 0;
        return $clog2(swt & -swt) + 1;
    endfunction

    // op: 0 pass, 1 raise, 2 lower
    function automatic int f_op(input int op, input int x);
        if (op == 1) return f_up(x);
        if (op == 2) return f_dn(x);
        return x;
    endfunction

    function automatic px_t f_model(input int mode, input int r, input int g, input int b,
                                    input int y, input int u, input int v,
                                    input int skin, input int c);
        px_t p;
        int  ops[3];
        int  x[3];
        int  t[3];
        bit  hit;
        x = '{r, g, b};
        ops = '{0, 0, 0};
        hit = 0;
        p.c = c;
        if (mode == 1) begin p.r = y; p.g = y; p.b = y; return p; end
        if (mode == 2) begin p.r = u; p.g = u; p.b = u; return p; end
        if (mode == 3) begin p.r = v; p.g = v; p.b = v; return p; end
        if (mode >= 4 && mode <= 7) hit = (skin != 0);
        if (mode >= 8)              hit = (skin == 0);
        case (mode)
            4: ops = '{2, 1, 2};
            5: ops = '{1, 2, 2};
            6: ops = '{2, 2, 1};
            7: ops = '{1, 1, 1};
            8: ops = '{1, 1, 1};
            9: ops = '{2, 2, 2};
            default: ops = '{0, 0, 0};
        endcase
        for (int i = 0; i < 3; i++) begin
            t[i] = hit ? f_op(ops[i], x[i]) : x[i];
`ifdef PIXSEL_BLEND_EN
            if (hit) t[i] = (t[i] * ALPHA + x[i] * (16 - ALPHA)) / 16;
`endif
        end
        p.r = t[0]; p.g = t[1]; p.b = t[2];
        return p;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_r, hold_g, hold_b;
    logic [CW-1:0] hold_c;
    bit            saw_backp = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) begin
                    if (in_c[VSB] && m_prev_vs == 0) m_mode = f_dec(int'(in_swt));
                    m_prev_vs = int'(in_c[VSB]);
                    q.push_back(f_model(m_mode, int'(in_r), int'(in_g), int'(in_b),
                                        int'(in_y), int'(in_u), int'(in_v),
                                        int'(in_skin), int'(in_c)));
                end
                if (in_valid && !in_ready) saw_backp = 1;
                if (stall_prev) begin
                    check("stall_hold_r", 32'(out_r), 32'(hold_r));
                    check("stall_hold_g", 32'(out_g), 32'(hold_g));
                    check("stall_hold_b", 32'(out_b), 32'(hold_b));
                    check("stall_hold_v", 32'(out_valid), 32'd1);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("sb_unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        px_t e;
                        e = q.pop_front();
                        check("sb_r", 32'(out_r), 32'(e.r));
                        check("sb_g", 32'(out_g), 32'(e.g));
                        check("sb_b", 32'(out_b), 32'(e.b));
                        check("sb_ctrl", 32'(out_ctrl), 32'(e.c));
                    end
                end
                stall_prev = out_valid && !out_ready;
                hold_r = out_r; hold_g = out_g; hold_b = out_b; hold_c = out_ctrl;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;  // 0: always 1, 1: pattern 1,0,0,1, 2: random, 3: held 0
    initial begin
        int pat[4];
        int idx;
        pat = '{1, 0, 0, 1};
        idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin out_ready = pat[idx % 4] != 0; idx++; end
                2:       out_ready = ($urandom_range(0, 1) != 0);
                3:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int r, input int g, input int b, input int y, input int u,
                         input int v, input int skin, input int c, input int swt);
        int k;
        in_r = DW'(r); in_g = DW'(g); in_b = DW'(b);
        in_y = DW'(y); in_u = DW'(u); in_v = DW'(v);
        in_skin = (skin != 0);
        in_c = CW'(c);
        in_swt = 8'(swt);
        in_valid = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
        end
        if (k == 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (LAT + 2) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int er, input int eg, input int eb,
                              output int lat);
        int k;
        k = 1;
        while (k < 20) begin
            @(negedge clk);
            if (out_valid) break;
            k++;
        end
        lat = k;
        if (k == 20) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_r"}, 32'(out_r), 32'(er));
            check({tag, "_g"}, 32'(out_g), 32'(eg));
            check({tag, "_b"}, 32'(out_b), 32'(eb));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; in_skin = 1'b0;
        in_r = '0; in_g = '0; in_b = '0; in_y = '0; in_u = '0; in_v = '0;
        in_c = '0; in_swt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_out_r", 32'(out_r), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: passthrough and latency
        drive(10, 20, 30, 1, 2, 3, 0, 0, 0);
        idle();
        expect_out("pass", 10, 20, 30, lat);
        check("pass_latency", 32'(lat), 32'(LAT));
        check("pass_mode", 32'(out_mode), 32'd0);
        drive(10, 20, 30, 1, 2, 3, 1, 0, 0);
        idle();
        expect_out("pass_skin", 10, 20, 30, lat);

        // 2: mode 4 latched at a frame start
        drive(1, 2, 3, 0, 0, 0, 0, 0, 8'h08);
        idle(); settle();
        drive(20, 240, 100, 0, 0, 0, 1, 1, 8'h08);
        idle();
        check("m4_mode", 32'(out_mode), 32'd4);
        expect_out("m4_skin", 0, 255, 68, lat);
        drive(50, 60, 70, 0, 0, 0, 0, 1, 8'h08);
        idle();
        expect_out("m4_nonskin", 50, 60, 70, lat);

        // 3: mode 9
        drive(5, 5, 5, 0, 0, 0, 1, 0, 8'hFF);
        idle(); settle();
        check("m9_not_yet", 32'(out_mode), 32'd4);
        drive(200, 31, 32, 0, 0, 0, 0, 1, 8'hFF);
        idle();
        check("m9_mode", 32'(out_mode), 32'd9);
        expect_out("m9_nonskin", 168, 0, 0, lat);
        drive(200, 31, 32, 0, 0, 0, 1, 1, 8'hFF);
        idle();
        expect_out("m9_skin", 200, 31, 32, lat);

        // 4: mid-frame switch change is deferred
        drive(9, 9, 9, 0, 0, 0, 1, 0, 8'h01);
        idle(); settle();
        drive(1, 2, 3, 77, 88, 99, 0, 1, 8'h01);
        idle();
        check("m1_mode", 32'(out_mode), 32'd1);
        expect_out("m1_grey_y", 77, 77, 77, lat);
        drive(1, 2, 3, 11, 22, 33, 0, 1, 8'h02);
        idle();
        check("m1_hold_mode", 32'(out_mode), 32'd1);
        expect_out("m1_hold_y", 11, 11, 11, lat);
        drive(1, 2, 3, 11, 22, 33, 0, 0, 8'h02);
        idle(); settle();
        check("m1_hold_vs0", 32'(out_mode), 32'd1);
        drive(1, 2, 3, 44, 99, 55, 0, 1, 8'h02);
        idle();
        check("m2_mode", 32'(out_mode), 32'd2);
        expect_out("m2_grey_u", 99, 99, 99, lat);

        // 5: continuous stream with 1,0,0,1 then random out_ready
        saw_backp = 0;
        for (int ph = 1; ph <= 2; ph++) begin
            rdy_mode = ph;
            for (int i = 0; i < 80; i++) begin
                int sw;
                case ($urandom_range(0, 3))
                    0:       sw = 0;
                    1:       sw = 8'hFF;
                    2:       sw = 1 << $urandom_range(0, 7);
                    default: sw = $urandom_range(0, 255);
                endcase
                drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 1), $urandom_range(0, 7), sw);
            end
            idle();
            rdy_mode = 0;
            for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
            #1;
            check("stream_drained", 32'(q.size()), 32'd0);
        end
        check("stream_backpressure_seen", 32'(saw_backp), 32'd1);

        // 6: reset mid-stream with two beats in flight
        rdy_mode = 3;
        @(posedge clk);
        #1;
        drive(1, 2, 3, 0, 0, 0, 1, 0, 8'h10);
        drive(4, 5, 6, 0, 0, 0, 1, 1, 8'h10);
        idle();
        check("pre_rst_mode", 32'(out_mode), 32'd5);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        q.delete();
        m_mode = 0;
        m_prev_vs = 0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_mode", 32'(out_mode), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        drive(12, 34, 56, 0, 0, 0, 1, 1, 0);
        idle();
        expect_out("post_rst_pass", 12, 34, 56, lat);
        settle();
        check("final_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixsel_pipe.md
Name: pixsel_pipe

Overview:
Parametrised, pipelined successor to the per-pixel effect selector in the video path. It sits between the colour-space/skin-detect stage and the display output. The block adds:
- a valid/ready handshake with backpressure;
- generic data width and saturation offsets;
- correct saturating arithmetic at both ends of the range;
- frame-synchronous mode switching, so a switch change never alters a frame part-way through.

Parameters:
DATA_W, 8, width of each colour/luma/chroma component
CTRL_W, 3, width of the sync/control sideband passed alongside pixels
VS_BIT, 0, index of the vsync bit within the ctrl sideband (frame-start marker)
UP_OFS, 64, offset added by the "raise" operation, saturating
DN_OFS, 32, offset subtracted by the "lower" operation, saturating
ALPHA, 8, blend weight in sixteenths (0..16); used only with PIXSEL_BLEND_EN

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_skin  in  1  skin-detect flag for this pixel
in_r, in_g, in_b  in  DATA_W each  RGB pixel
in_y, in_u, in_v  in  DATA_W each  YUV pixel
in_c  in  CTRL_W  sync sideband
in_swt  in  8  mode switches
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_r, out_g, out_b  out  DATA_W each  processed pixel
out_ctrl  out  CTRL_W  sideband, delayed in step with the pixel
out_mode  out  4  mode currently applied

Behaviour:
Reset (rst_n low, asynchronous) clears:
- all outputs, out_valid, both stage-valid flags and the mode register;
- the prev-vsync flag.
After reset:
- out_mode = 0 (passthrough);
- in_ready = 1.

Mode decode:
- in_swt = 8'hFF gives mode 9.
- in_swt = 0 gives mode 0.
- Otherwise the lowest set bit k gives mode k+1.

Mode effects:
- 0: passthrough.
- 1: grey Y. 2: grey U. 3: grey V. Each writes the selected channel to all three outputs.
- 4: skin pixels become (dn r, up g, dn b).
- 5: skin pixels become (up r, dn g, dn b).
- 6: skin pixels become (dn r, dn g, up b).
- 7: skin pixels become (up r, up g, up b).
- 8: non-skin pixels become (up r, up g, up b).
- 9: non-skin pixels become (dn r, dn g, dn b).
- In modes 4-9, pixels not named by the mode pass through unchanged.

Saturating arithmetic:
- up(x) = min(x + UP_OFS, 2^DATA_W - 1).
- dn(x) = max(x - DN_OFS, 0).
- Both are computed in DATA_W+2 bits signed. There is no wrap-around at either end.

Frame-synchronous mode:
- The applied mode register loads the decoded in_swt only on an accepted input beat that is a frame start.
- A frame start is in_c[VS_BIT] = 1 while the previous accepted beat had in_c[VS_BIT] = 0.
- The frame-start beat itself uses the new mode.
- in_swt changes at any other time are ignored until the next frame start.
- The prev-vsync flag updates only on accepted beats.

Pipeline:
- Two stages.
- S1 registers the inputs, computes up/dn for every channel and resolves the mode.
- S2 selects the output and registers out_*.
- Latency is 2 cycles from acceptance to out_valid when out_ready stays high.
- Throughput is 1 beat per cycle.

Handshake:
- An input beat is accepted when in_valid && in_ready.
- An output beat is consumed when out_valid && out_ready.
- S2 loads when !v2 || out_ready.
- S1 loads when !v1 || S2 loads.
- in_ready = !v1 || !v2 || out_ready. This combinational path from out_ready is permitted.
- out_* hold stable while out_valid && !out_ready.
- No beat is dropped or duplicated. in_c travels with its pixel.
- A reset asserted mid-stream discards every in-flight beat.

Optional Feature:
PIXSEL_BLEND_EN:
- Defined: in modes 4-9, each affected channel outputs (t*ALPHA + x*(16-ALPHA)) >> 4, where t is the tinted value and x the input value. The blend adds one stage, so latency becomes 3 and the handshake rules extend to three stages.
- Undefined: the tinted value is output directly, latency is 2, and ALPHA is ignored.

Test Plan:
1. Reset, then in_swt = 0 and a stream r/g/b = 10/20/30 with out_ready = 1 -> identical pixels appear 2 cycles after acceptance; out_mode = 0.
2. in_swt = 8'h08 set at a frame start; skin pixel (r,g,b) = (20,240,100) -> output (0,255,68); non-skin pixel passes unchanged.
3. in_swt = 8'hFF at a frame start; non-skin pixel (200,31,32) -> (168,0,0); skin pixel unchanged.
4. in_swt changed from 8'h01 to 8'h02 mid-frame -> out_mode stays 1 until the next 0->1 edge on in_c[VS_BIT]; that beat and later beats use mode 2 and output U on all channels.
5. Continuous in_valid with out_ready toggling 1,0,0,1 -> in_ready drops once both stages are full; the output sequence equals the input sequence with no loss; out_* stay stable during stalls.
6. rst_n pulsed low for 1 cycle with 2 beats in flight -> out_valid drops immediately; out_mode = 0; no stale beat appears afterwards.
